// File: rtl/freertos_nios_oci_pkg.sv
// Shared definitions for the Nios OCI memory arbiter: FSM states, grant ids,
// debug command word layout and the decoded JTAG command opcodes.
package freertos_nios_oci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_CPU_RD,
        ST_JTAG_ACC,
        ST_JTAG_RD
    } state_e;

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_JTAG = 1'b1
    } grant_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_SET_ADDR,
        CMD_SET_ADDR_RD,
        CMD_READ,
        CMD_WRITE
    } jtag_cmd_e;

    // Layout of the 38-bit debug command word.
    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_MSB  = 33;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_RD_BIT    = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    function automatic jtag_cmd_e decode_cmd(input logic act_a, input logic act_b,
                                             input logic no_act_a, input logic rd_bit);
        jtag_cmd_e cmd;
        cmd = CMD_NONE;
        if (act_a) begin
            cmd = rd_bit ? CMD_SET_ADDR_RD : CMD_SET_ADDR;
        end else if (act_b) begin
            cmd = CMD_WRITE;
        end else if (no_act_a) begin
            cmd = CMD_READ;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/freertos_nios_rr_arb2.sv
// Two-requester round-robin arbiter between the CPU and the JTAG slot.
// The history only moves on real contention, so an uncontested grant keeps the turn.
module freertos_nios_rr_arb2
    import freertos_nios_oci_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic req_cpu,
    input  logic req_jtag,
    output logic gnt_cpu,
    output logic gnt_jtag
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        last_grant_d = last_grant_q;
        gnt_jtag     = req_jtag && (!req_cpu || (last_grant_q == GNT_CPU));
        gnt_cpu      = req_cpu && !gnt_jtag;
        if (advance && req_cpu && req_jtag) begin
            last_grant_d = gnt_jtag ? GNT_JTAG : GNT_CPU;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_CPU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/freertos_nios_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the CPU Avalon slave and the JTAG
// debug path; RAM strobes are registered, read data passes straight through.
module freertos_nios_ocimem_arbiter
    import freertos_nios_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    state_e              state_q,       state_d;
    logic                waitreq_q,     waitreq_d;
    logic [ADDR_W-1:0]   ram_addr_q,    ram_addr_d;
    logic                ram_rd_q,      ram_rd_d;
    logic                ram_wr_q,      ram_wr_d;
    logic [DATA_W-1:0]   ram_wdata_q,   ram_wdata_d;
    logic [3:0]          ram_be_q,      ram_be_d;
    logic                mon_ready_q,   mon_ready_d;
    logic                overrun_q,     overrun_d;
    logic [ADDR_W-1:0]   mon_a_q,       mon_a_d;
    logic [DATA_W-1:0]   mon_d_q,       mon_d_d;
    logic                slot_valid_q,  slot_valid_d;
    logic                slot_wr_q,     slot_wr_d;
    logic [DATA_W-1:0]   slot_wdata_q,  slot_wdata_d;

    logic                gnt_cpu;
    logic                gnt_jtag;
    logic                completing;
    jtag_cmd_e           cmd;
    logic [ADDR_W-1:0]   jdo_addr;
    logic [DATA_W-1:0]   jdo_wdata;
    logic                unused_jdo;

    assign jdo_addr   = ADDR_W'(jdo[JDO_ADDR_MSB:JDO_ADDR_LSB]);
    assign jdo_wdata  = DATA_W'(jdo[JDO_WDATA_MSB:JDO_WDATA_LSB]);
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};
    assign cmd        = decode_cmd(take_action_ocimem_a, take_action_ocimem_b,
                                   take_no_action_ocimem_a, jdo[JDO_RD_BIT]);

    freertos_nios_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .advance  (state_q == ST_IDLE),
        .req_cpu  (cpu_read || cpu_write),
        .req_jtag (slot_valid_q),
        .gnt_cpu  (gnt_cpu),
        .gnt_jtag (gnt_jtag)
    );

    always_comb begin
        state_d      = state_q;
        waitreq_d    = 1'b1;
        ram_addr_d   = '0;
        ram_rd_d     = 1'b0;
        ram_wr_d     = 1'b0;
        ram_wdata_d  = '0;
        ram_be_d     = '0;
        mon_ready_d  = 1'b0;
        overrun_d    = overrun_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        slot_valid_d = slot_valid_q;
        slot_wr_d    = slot_wr_q;
        slot_wdata_d = slot_wdata_q;
        completing   = 1'b0;

        // Outputs are set up one cycle ahead so they appear registered in the access state.
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_cpu) begin
                    state_d    = ST_CPU_ACC;
                    ram_addr_d = cpu_address;
                    ram_be_d   = cpu_byteenable;
                    if (cpu_write) begin
                        ram_wr_d    = 1'b1;
                        ram_wdata_d = cpu_writedata;
                        waitreq_d   = 1'b0;
                    end else begin
                        ram_rd_d = 1'b1;
                    end
                end else if (gnt_jtag) begin
                    state_d    = ST_JTAG_ACC;
                    ram_addr_d = mon_a_q;
                    ram_be_d   = 4'hF;
                    if (slot_wr_q) begin
                        ram_wr_d    = 1'b1;
                        ram_wdata_d = slot_wdata_q;
                        mon_ready_d = 1'b1;
                    end else begin
                        ram_rd_d = 1'b1;
                    end
                end
            end
            ST_CPU_ACC: begin
                if (ram_wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_CPU_RD;
                    waitreq_d = 1'b0;
                end
            end
            ST_CPU_RD: state_d = ST_IDLE;
            ST_JTAG_ACC: begin
                if (ram_wr_q) begin
                    state_d    = ST_IDLE;
                    completing = 1'b1;
                end else begin
                    state_d = ST_JTAG_RD;
                end
            end
            ST_JTAG_RD: begin
                // monitor_ready rises together with the freshly captured MonDReg.
                state_d     = ST_IDLE;
                mon_d_d     = ram_rdata;
                mon_ready_d = 1'b1;
                completing  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (completing) begin
            slot_valid_d = 1'b0;
            mon_a_d      = mon_a_q + 1'b1;
        end

        // A strobe in the completion cycle lands in the slot being freed.
        if (cmd != CMD_NONE) begin
            if (slot_valid_q && !completing) begin
                overrun_d = 1'b1;
            end else begin
                unique case (cmd)
                    CMD_SET_ADDR: mon_a_d = jdo_addr;
                    CMD_SET_ADDR_RD: begin
                        mon_a_d      = jdo_addr;
                        slot_valid_d = 1'b1;
                        slot_wr_d    = 1'b0;
                    end
                    CMD_WRITE: begin
                        slot_valid_d = 1'b1;
                        slot_wr_d    = 1'b1;
                        slot_wdata_d = jdo_wdata;
                    end
                    CMD_READ: begin
                        slot_valid_d = 1'b1;
                        slot_wr_d    = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            waitreq_q    <= 1'b1;
            ram_addr_q   <= '0;
            ram_rd_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            mon_ready_q  <= 1'b0;
            overrun_q    <= 1'b0;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            slot_valid_q <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            waitreq_q    <= waitreq_d;
            ram_addr_q   <= ram_addr_d;
            ram_rd_q     <= ram_rd_d;
            ram_wr_q     <= ram_wr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            mon_ready_q  <= mon_ready_d;
            overrun_q    <= overrun_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            slot_valid_q <= slot_valid_d;
            slot_wr_q    <= slot_wr_d;
            slot_wdata_q <= slot_wdata_d;
        end
    end

    assign cpu_readdata    = (state_q == ST_CPU_RD) ? ram_rdata : '0;
    assign cpu_waitrequest = waitreq_q;
    assign ram_addr        = ram_addr_q;
    assign ram_rd          = ram_rd_q;
    assign ram_wr          = ram_wr_q;
    assign ram_wdata       = ram_wdata_q;
    assign ram_be          = ram_be_q;
    assign MonDReg         = mon_d_q;
    assign monitor_ready   = mon_ready_q;
    assign jtag_overrun    = overrun_q;

endmodule

// File: tb/tb_freertos_nios_ocimem_arbiter.sv
// Scoreboard bench for the OCI memory arbiter: directed stimulus pushes the
// expected RAM writes, CPU read data and JTAG results; a monitor pops and compares.
module tb_freertos_nios_ocimem_arbiter;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } jt_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_rd, ram_wr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    wr_t         wr_exp[$];
    logic [31:0] cpu_exp[$];
    jt_t         jtag_exp[$];
    logic [8:0]  ram_log[$];

    int n_checks = 0;
    int n_err    = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int mon_cnt  = 0;
    int viol     = 0;

    logic [31:0] mem [256];
    bit          mem_loaded = 1'b0;

    always #5 clk = ~clk;

    freertos_nios_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_rd                  (ram_rd),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    // RAM model: word i preloads to 0xA5000000 | i, one-cycle read latency.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem_loaded <= 1'b1;
            ram_rdata  <= '0;
        end else begin
            if (ram_wr) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            if (ram_rd) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        logic mon_prev;
        wr_t  w;
        jt_t  j;
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ram_rd && ram_wr) viol++;
            if (monitor_ready && mon_prev) viol++;
            mon_prev = monitor_ready;
            if (ram_wr) begin
                wr_cnt++;
                ram_log.push_back({1'b1, ram_addr});
                if (wr_exp.size() == 0) check("ram_wr_unexpected", 1, 0);
                else begin
                    w = wr_exp.pop_front();
                    check("ram_wr", {20'd0, ram_addr, ram_be, ram_wdata}, {20'd0, w});
                end
            end
            if (ram_rd) begin
                rd_cnt++;
                ram_log.push_back({1'b0, ram_addr});
            end
            if (!cpu_waitrequest && cpu_read) begin
                if (cpu_exp.size() == 0) check("cpu_rd_unexpected", 1, 0);
                else check("cpu_readdata", {32'd0, cpu_readdata}, {32'd0, cpu_exp.pop_front()});
            end
            if (monitor_ready) begin
                mon_cnt++;
                if (jtag_exp.size() == 0) check("monitor_ready_unexpected", 1, 0);
                else begin
                    j = jtag_exp.pop_front();
                    if (j.rd) check("MonDReg", {32'd0, MonDReg}, {32'd0, j.data});
                end
            end
        end
    end

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[33:26] = addr;
        v[17]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issues one CPU access; lat counts cycles from the request to waitrequest low.
    task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] rd_exp,
                              output int lat, output logic wr_at_ack);
        int budget;
        if (wr) wr_exp.push_back('{addr: a, be: be, data: d});
        else    cpu_exp.push_back(rd_exp);
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address    = a;
        cpu_writedata  = d;
        cpu_byteenable = be;
        cpu_write      = wr;
        cpu_read       = !wr;
        lat       = 0;
        wr_at_ack = 1'b0;
        budget    = 0;
        forever begin
            @(negedge clk);
            if (!cpu_waitrequest) begin
                wr_at_ack = ram_wr;
                break;
            end
            lat++;
            budget++;
            if (budget > 50) begin
                check("cpu_waitrequest_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic wait_mon(input int target);
        int c;
        c = 0;
        while (mon_cnt < target && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("monitor_ready_wait", {63'd0, mon_cnt >= target}, 1);
    endtask

    initial begin
        int          lat;
        logic        wa;
        int          base;
        logic [8:0]  e;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", {63'd0, cpu_waitrequest}, 1);
        check("rst_readdata", {32'd0, cpu_readdata}, 0);
        check("rst_ram_strobes", {62'd0, ram_rd, ram_wr}, 0);
        check("rst_ram_addr", {56'd0, ram_addr}, 0);
        check("rst_MonDReg", {32'd0, MonDReg}, 0);
        check("rst_monitor_ready", {63'd0, monitor_ready}, 0);
        check("rst_overrun", {63'd0, jtag_overrun}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // CPU write then read, plus a byte-lane write.
        cpu_access(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, '0, lat, wa);
        check("cpu_wr_latency", 64'(lat), 1);
        check("cpu_wr_ram_wr_at_ack", {63'd0, wa}, 1);
        cpu_access(1'b0, 8'h10, '0, 4'hF, 32'hDEAD_BEEF, lat, wa);
        check("cpu_rd_latency", 64'(lat), 2);
        cpu_access(1'b1, 8'h10, 32'h1234_5678, 4'b0011, '0, lat, wa);
        cpu_access(1'b0, 8'h10, '0, 4'hF, 32'hDEAD_5678, lat, wa);
        cpu_access(1'b0, 8'h33, '0, 4'hF, 32'hA500_0033, lat, wa);

        // JTAG read at the top address, then wrap to 0.
        base = mon_cnt;
        jtag_exp.push_back('{rd: 1'b1, data: 32'hA500_00FF});
        @(posedge clk); #1 jdo = jdo_a(8'hFF, 1'b1); take_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_action_ocimem_a = 1'b0;
        wait_mon(base + 1);
        repeat (3) @(negedge clk);
        check("single_monitor_pulse", 64'(mon_cnt - base), 1);
        jtag_exp.push_back('{rd: 1'b1, data: 32'hA500_0000});
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b0;
        wait_mon(base + 2);

        // Contention: JTAG wins first, CPU wins the second pair.
        do_reset();
        ram_log.delete();
        base = mon_cnt;
        wr_exp.push_back('{addr: 8'h00, be: 4'hF, data: 32'h1111_0000});
        jtag_exp.push_back('{rd: 1'b0, data: '0});
        @(posedge clk); #1 jdo = jdo_b(32'h1111_0000); take_action_ocimem_b = 1'b1;
        cpu_access(1'b0, 8'h20, '0, 4'hF, 32'hA500_0020, lat, wa);
        check("contend1_cpu_latency", 64'(lat), 4);
        wait_mon(base + 1);
        e = ram_log.size() > 0 ? ram_log.pop_front() : 9'h1FF;
        check("contend1_first_op", {55'd0, e}, {55'd0, 9'h100});
        e = ram_log.size() > 0 ? ram_log.pop_front() : 9'h1FF;
        check("contend1_second_op", {55'd0, e}, {55'd0, 9'h020});
        ram_log.delete();
        wr_exp.push_back('{addr: 8'h01, be: 4'hF, data: 32'h2222_0000});
        jtag_exp.push_back('{rd: 1'b0, data: '0});
        @(posedge clk); #1 jdo = jdo_b(32'h2222_0000); take_action_ocimem_b = 1'b1;
        cpu_access(1'b0, 8'h21, '0, 4'hF, 32'hA500_0021, lat, wa);
        check("contend2_cpu_latency", 64'(lat), 2);
        wait_mon(base + 2);
        e = ram_log.size() > 0 ? ram_log.pop_front() : 9'h1FF;
        check("contend2_first_op", {55'd0, e}, {55'd0, 9'h021});
        e = ram_log.size() > 0 ? ram_log.pop_front() : 9'h1FF;
        check("contend2_second_op", {55'd0, e}, {55'd0, 9'h101});

        // Back-to-back write strobes: the second is dropped.
        base = wr_cnt;
        wr_exp.push_back('{addr: 8'h02, be: 4'hF, data: 32'hCAFE_F00D});
        jtag_exp.push_back('{rd: 1'b0, data: '0});
        @(posedge clk); #1 jdo = jdo_b(32'hCAFE_F00D); take_action_ocimem_b = 1'b1;
        @(posedge clk); #1 jdo = jdo_b(32'hBAD0_BAD0);
        @(posedge clk); #1 take_action_ocimem_b = 1'b0;
        repeat (8) @(negedge clk);
        check("overrun_ram_writes", 64'(wr_cnt - base), 1);
        check("overrun_flag", {63'd0, jtag_overrun}, 1);

        // Strobe in the completion cycle is accepted.
        do_reset();
        @(negedge clk);
        check("overrun_cleared", {63'd0, jtag_overrun}, 0);
        base = mon_cnt;
        jtag_exp.push_back('{rd: 1'b1, data: 32'hA500_0040});
        jtag_exp.push_back('{rd: 1'b1, data: 32'hA500_0041});
        @(posedge clk); #1 jdo = jdo_a(8'h40, 1'b1); take_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_action_ocimem_a = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b0;
        wait_mon(base + 2);
        check("completion_strobe_no_overrun", {63'd0, jtag_overrun}, 0);

        // Reset during CPU_RD with a JTAG read waiting in the slot.
        cpu_exp.push_back(32'hA500_0050);
        @(posedge clk); #1 cpu_address = 8'h50; cpu_byteenable = 4'hF;
        cpu_read = 1'b1; take_no_action_ocimem_a = 1'b1;
        @(posedge clk); #1 take_no_action_ocimem_a = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; cpu_read = 1'b0;
        @(negedge clk);
        check("abort_waitrequest", {63'd0, cpu_waitrequest}, 1);
        check("abort_ram_strobes", {62'd0, ram_rd, ram_wr}, 0);
        check("abort_readdata", {32'd0, cpu_readdata}, 0);
        base = rd_cnt + wr_cnt;
        lat  = mon_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_ram_ops", 64'(rd_cnt + wr_cnt - base), 0);
        check("abort_slot_empty", 64'(mon_cnt - lat), 0);

        check("wr_exp_drained", 64'(wr_exp.size()), 0);
        check("cpu_exp_drained", 64'(cpu_exp.size()), 0);
        check("jtag_exp_drained", 64'(jtag_exp.size()), 0);
        check("protocol_violations", 64'(viol), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/freertos_nios_ocimem_arbiter.md
FREERTOS_NIOS_OCIMEM_ARBITER -- requirements
Module: freertos_nios_ocimem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, OCI RAM word-address width; DATA_W, default 32, data width.
REQ-002 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 jdo  in  38  debug command word from the debug slave sysclk stage.
REQ-005 take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a  in  1 each  single-cycle JTAG command strobes.
REQ-006 cpu_address  in  ADDR_W; cpu_read, cpu_write  in  1; cpu_writedata  in  DATA_W; cpu_byteenable  in  4: CPU Avalon slave request.
REQ-007 cpu_readdata  out  DATA_W; cpu_waitrequest  out  1: CPU Avalon slave response.
REQ-008 ram_addr  out  ADDR_W; ram_rd, ram_wr  out  1; ram_wdata  out  DATA_W; ram_be  out  4; ram_rdata  in  DATA_W: shared single-port OCI RAM with 1-cycle read latency.
REQ-009 MonDReg  out  DATA_W  last JTAG read data; monitor_ready  out  1  one-cycle pulse on JTAG access completion; jtag_overrun  out  1  sticky dropped-command flag.

Function
REQ-010 JTAG command decode:
- take_action_ocimem_a: load JTAG address MonAReg <= jdo[33:26]; if jdo[17]=1, post a read.
- take_action_ocimem_b: post a write of jdo[34:3] to MonAReg, byte enables 4'hF.
- take_no_action_ocimem_a: post a read at MonAReg.
REQ-011 The JTAG side SHALL hold one pending slot; a strobe arriving while the slot is full, or while a JTAG access is in progress, SHALL be dropped and SHALL set jtag_overrun until reset.
REQ-012 MonAReg SHALL increment by 1 on completion of every JTAG read or write, wrapping from 2^ADDR_W-1 to 0.
REQ-013 The FSM SHALL have states IDLE, CPU_ACC, CPU_RD, JTAG_ACC, JTAG_RD.
REQ-014 In IDLE, arbitration SHALL work as follows:
- only one requester: that requester is granted;
- both CPU and JTAG pending: the requester not granted last is granted (round-robin);
- last_grant SHALL reset to CPU, so JTAG wins the first contention.
REQ-015 CPU_ACC SHALL drive ram_addr=cpu_address and ram_be=cpu_byteenable.
- Write: ram_wr=1, ram_wdata=cpu_writedata, cpu_waitrequest=0, next state IDLE.
- Read: ram_rd=1, next state CPU_RD.
REQ-016 CPU_RD SHALL drive cpu_readdata=ram_rdata and cpu_waitrequest=0, then return to IDLE.
REQ-017 CPU timing: a CPU write first seen in IDLE SHALL be accepted in cycle N+1; an uncontested read SHALL complete in cycle N+2.
REQ-018 cpu_waitrequest SHALL be 1 in every cycle not named in REQ-015/016; CPU request signals are held by the master and SHALL NOT be captured.
REQ-019 JTAG_ACC SHALL drive ram_addr=MonAReg.
- Write: ram_wr=1, monitor_ready pulse, next state IDLE.
- Read: ram_rd=1, next state JTAG_RD.
REQ-020 JTAG_RD SHALL perform MonDReg <= ram_rdata, pulse monitor_ready and return to IDLE; the pending slot SHALL clear on completion.
REQ-021 ram_rd and ram_wr SHALL never both be 1 in the same cycle; ram_* outputs SHALL be 0 in IDLE.
REQ-022 A JTAG strobe coinciding with its own completion cycle SHALL be accepted into the freed slot, not dropped.

Reset
REQ-023 Reset SHALL force all of the following, regardless of any access in progress; an aborted access SHALL leave no pending state:
- state=IDLE, pending slot empty, last_grant=CPU;
- MonAReg=0, MonDReg=0, jtag_overrun=0, monitor_ready=0;
- cpu_waitrequest=1, cpu_readdata=0, all ram_* outputs 0.

Structure
REQ-024 FSM state encoding, the jdo bit-field positions and the JTAG command opcodes SHALL reside in the shared package freertos_nios_oci_pkg.
REQ-025 The two-requester round-robin decision SHALL be a sub-module, freertos_nios_rr_arb2; all other logic SHALL be flat.

Verification
REQ-026 Reset, then CPU write 0xDEADBEEF to address 0x10 -> ram_wr=1 with ram_addr=0x10 in cycle N+1, waitrequest low in the same cycle; a following read returns 0xDEADBEEF at cycle N+2.
REQ-027 take_action_ocimem_a with jdo[33:26]=0xFF and jdo[17]=1 -> MonDReg=RAM[0xFF], one monitor_ready pulse, MonAReg wraps to 0x00.
REQ-028 CPU read and JTAG write pending in the same IDLE cycle after reset -> JTAG granted first, CPU granted next; a second simultaneous pair is granted CPU first.
REQ-029 Two take_action_ocimem_b strobes one cycle apart while the first is pending -> second dropped, jtag_overrun=1, exactly one RAM write.
REQ-030 Reset asserted during CPU_RD -> next cycle state IDLE, cpu_waitrequest=1, no ram_rd/ram_wr, pending slot empty.
